// File: rtl/vc_wormhole_cross_bar.sv
// vc_wormhole_cross_bar
// Registered PORT_NUM x PORT_NUM crossbar with per-output wormhole locking.
// Each output follows one packet from its header to its tail. While IDLE, an
// output accepts header/single flits steered by the switch-allocator port
// select. While LOCKED, it accepts only body/tail flits from the owning input.
// Every forwarded flit has its output-VC field replaced. Header and single flits
// also have their destination field replaced with the look-ahead port.
//
// Ports:
//   clk                        rising-edge clock
//   reset                      asynchronous, active-high
//   flit_in_array              input flits, slice i = input i
//   flit_in_wr                 flit valid per input
//   port_sel_array             one-hot output select per input (self excluded)
//   look_ahead_port_sel_array  next-router port per input
//   ovc_array                  one-hot output VC per input
//   flit_out_array             registered output flits (hold when idle)
//   flit_out_wr                registered output valid
//   out_locked                 output currently owned by a packet
//   conflict_err               sticky per-output collision flag
module vc_wormhole_cross_bar #(
   parameter int PORT_NUM           = 5,
   parameter int VC_NUM_PER_PORT    = 4,
   parameter int PYLD_WIDTH         = 32,
   parameter int FLIT_TYPE_WIDTH    = 2,
   parameter int FLIT_WIDTH         = PYLD_WIDTH + FLIT_TYPE_WIDTH + VC_NUM_PER_PORT,
   parameter int PORT_NUM_BCD_WIDTH = $clog2(PORT_NUM),
   parameter int PORT_SEL_WIDTH     = PORT_NUM - 1
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [FLIT_WIDTH*PORT_NUM-1:0]         flit_in_array,
   input  logic [PORT_NUM-1:0]                    flit_in_wr,
   input  logic [PORT_SEL_WIDTH*PORT_NUM-1:0]     port_sel_array,
   input  logic [PORT_NUM_BCD_WIDTH*PORT_NUM-1:0] look_ahead_port_sel_array,
   input  logic [VC_NUM_PER_PORT*PORT_NUM-1:0]    ovc_array,
   output logic [FLIT_WIDTH*PORT_NUM-1:0]         flit_out_array,
   output logic [PORT_NUM-1:0]                    flit_out_wr,
   output logic [PORT_NUM-1:0]                    out_locked,
   output logic [PORT_NUM-1:0]                    conflict_err
);

   localparam int OVC_MSB = FLIT_WIDTH - FLIT_TYPE_WIDTH - 1;

   typedef enum logic {StIdle, StLocked} state_e;

   // Rewritten copy of every input flit; an output just picks one of these.
   function automatic logic [FLIT_WIDTH-1:0] rewrite(
      input logic [FLIT_WIDTH-1:0]         flit,
      input logic [VC_NUM_PER_PORT-1:0]    ovc,
      input logic [PORT_NUM_BCD_WIDTH-1:0] lookahead
   );
      logic [FLIT_WIDTH-1:0] f;
      f = flit;
      f[OVC_MSB -: VC_NUM_PER_PORT] = ovc;
      // Type MSB set means header or single: destination field is replaced.
      if (flit[FLIT_WIDTH-1]) f[PYLD_WIDTH-1 -: PORT_NUM_BCD_WIDTH] = lookahead;
      return f;
   endfunction

   logic [FLIT_WIDTH-1:0]           flit_rw [PORT_NUM];
   logic [FLIT_TYPE_WIDTH-1:0]      ftype   [PORT_NUM];
   // hit[o][i]: input i's port select points at output o.
   logic [PORT_NUM-1:0][PORT_NUM-1:0] hit;

   state_e                          state_q [PORT_NUM];
   state_e                          state_d [PORT_NUM];
   logic [PORT_NUM_BCD_WIDTH-1:0]   owner_q [PORT_NUM];
   logic [PORT_NUM_BCD_WIDTH-1:0]   owner_d [PORT_NUM];
   logic [FLIT_WIDTH-1:0]           flit_q  [PORT_NUM];
   logic [FLIT_WIDTH-1:0]           flit_d  [PORT_NUM];
   logic [PORT_NUM-1:0]             wr_q, wr_d;
   logic [PORT_NUM-1:0]             err_q, err_d;
   logic                            taken;
   logic                            hdr_req;

   for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_in
      assign ftype[gi]   = flit_in_array[gi*FLIT_WIDTH + FLIT_WIDTH - 1 -: FLIT_TYPE_WIDTH];
      assign flit_rw[gi] = rewrite(
         flit_in_array[gi*FLIT_WIDTH +: FLIT_WIDTH],
         ovc_array[gi*VC_NUM_PER_PORT +: VC_NUM_PER_PORT],
         look_ahead_port_sel_array[gi*PORT_NUM_BCD_WIDTH +: PORT_NUM_BCD_WIDTH]);
      // The select vector omits the input's own port, so bits above it shift down.
      for (genvar go = 0; go < PORT_NUM; go++) begin : g_out
         if (go == gi) begin : g_self
            assign hit[go][gi] = 1'b0;
         end else if (go > gi) begin : g_above
            assign hit[go][gi] = port_sel_array[gi*PORT_SEL_WIDTH + go - 1];
         end else begin : g_below
            assign hit[go][gi] = port_sel_array[gi*PORT_SEL_WIDTH + go];
         end
      end
   end

   always_comb begin
      taken   = 1'b0;
      hdr_req = 1'b0;
      wr_d    = '0;
      err_d   = err_q;
      for (int o = 0; o < PORT_NUM; o++) begin
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         flit_d[o]  = flit_q[o];
         taken      = 1'b0;
         for (int i = 0; i < PORT_NUM; i++) begin
            hdr_req = flit_in_wr[i] && ftype[i][1] && hit[o][i];
            if (state_q[o] == StIdle) begin
               // Lowest index wins; any further header for this output collides.
               if (hdr_req) begin
                  if (!taken) begin
                     taken     = 1'b1;
                     wr_d[o]   = 1'b1;
                     flit_d[o] = flit_rw[i];
                     if (!ftype[i][0]) begin
                        state_d[o] = StLocked;
                        owner_d[o] = PORT_NUM_BCD_WIDTH'(i);
                     end
                  end else begin
                     err_d[o] = 1'b1;
                  end
               end
            end else begin
               if (hdr_req) err_d[o] = 1'b1;
               if (flit_in_wr[i] && !ftype[i][1] && owner_q[o] == PORT_NUM_BCD_WIDTH'(i)) begin
                  wr_d[o]   = 1'b1;
                  flit_d[o] = flit_rw[i];
                  if (ftype[i][0]) state_d[o] = StIdle;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int o = 0; o < PORT_NUM; o++) begin
            state_q[o] <= StIdle;
            owner_q[o] <= '0;
            flit_q[o]  <= '0;
         end
         wr_q  <= '0;
         err_q <= '0;
      end else begin
         for (int o = 0; o < PORT_NUM; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
            flit_q[o]  <= flit_d[o];
         end
         wr_q  <= wr_d;
         err_q <= err_d;
      end
   end

   for (genvar go = 0; go < PORT_NUM; go++) begin : g_flat
      assign flit_out_array[go*FLIT_WIDTH +: FLIT_WIDTH] = flit_q[go];
      assign out_locked[go] = (state_q[go] == StLocked);
   end

   assign flit_out_wr  = wr_q;
   assign conflict_err = err_q;

endmodule

// File: tb/tb_vc_wormhole_cross_bar.sv
module tb_vc_wormhole_cross_bar;
   localparam int P  = 5;
   localparam int VC = 4;
   localparam int FW = 38;
   localparam int BW = 3;
   localparam int SW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [FW*P-1:0] flit_in_array;
   logic [P-1:0]    flit_in_wr;
   logic [SW*P-1:0] port_sel_array;
   logic [BW*P-1:0] look_ahead_port_sel_array;
   logic [VC*P-1:0] ovc_array;
   logic [FW*P-1:0] flit_out_array;
   logic [P-1:0]    flit_out_wr;
   logic [P-1:0]    out_locked;
   logic [P-1:0]    conflict_err;

   vc_wormhole_cross_bar dut (
      .clk                       (clk),
      .reset                     (reset),
      .flit_in_array             (flit_in_array),
      .flit_in_wr                (flit_in_wr),
      .port_sel_array            (port_sel_array),
      .look_ahead_port_sel_array (look_ahead_port_sel_array),
      .ovc_array                 (ovc_array),
      .flit_out_array            (flit_out_array),
      .flit_out_wr               (flit_out_wr),
      .out_locked                (out_locked),
      .conflict_err              (conflict_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [P-1:0]    wr;
      logic [FW*P-1:0] fl;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [3:0] v,
                                        input logic [31:0] p);
      return {t, v, p};
   endfunction

   task automatic clear_inputs();
      flit_in_wr = '0;
      flit_in_array = '0;
      port_sel_array = '0;
      look_ahead_port_sel_array = '0;
      ovc_array = '0;
      cur = '0;
   endtask

   task automatic put(input int i, input logic [FW-1:0] f, input logic [3:0] sel,
                      input logic [3:0] v, input logic [2:0] l);
      flit_in_array[i*FW +: FW] = f;
      flit_in_wr[i] = 1'b1;
      port_sel_array[i*SW +: SW] = sel;
      ovc_array[i*VC +: VC] = v;
      look_ahead_port_sel_array[i*BW +: BW] = l;
   endtask

   task automatic expect_out(input int o, input logic [FW-1:0] f);
      cur.wr[o] = 1'b1;
      cur.fl[o*FW +: FW] = f;
   endtask

   // Queue this cycle's expectation, let the edge happen, start the next cycle clean.
   task automatic tick();
      sb.push_back(cur);
      @(negedge clk);
      clear_inputs();
   endtask

   // Scoreboard monitor: every edge pops one expectation (none queued = no output).
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) mon_e = sb.pop_front();
      else mon_e = '0;
      checks++;
      if (flit_out_wr !== mon_e.wr) begin
         errors++;
         $display("FAIL sb_wr @%0t: got %b want %b", $time, flit_out_wr, mon_e.wr);
      end
      for (int o = 0; o < P; o++) begin
         if (mon_e.wr[o]) begin
            checks++;
            if (flit_out_array[o*FW +: FW] !== mon_e.fl[o*FW +: FW]) begin
               errors++;
               $display("FAIL sb_flit_out%0d @%0t: got %h want %h", o, $time,
                        flit_out_array[o*FW +: FW], mon_e.fl[o*FW +: FW]);
            end
         end
      end
   end

   task automatic test_reset();
      checks++;
      if (flit_out_wr !== 5'b0) begin
         errors++; $display("FAIL rst_wr: got %b want 00000", flit_out_wr);
      end
      checks++;
      if (flit_out_array !== '0) begin
         errors++; $display("FAIL rst_flits: got %h want 0", flit_out_array);
      end
      checks++;
      if (out_locked !== 5'b0) begin
         errors++; $display("FAIL rst_locked: got %b want 00000", out_locked);
      end
      checks++;
      if (conflict_err !== 5'b0) begin
         errors++; $display("FAIL rst_err: got %b want 00000", conflict_err);
      end
   endtask

   task automatic test_single();
      logic [31:0] p;
      p = 32'hA5A5_1234;
      put(0, mk(2'b11, 4'b0001, p), 4'b0010, 4'b0100, 3'd3);
      expect_out(2, mk(2'b11, 4'b0100, {3'd3, p[28:0]}));
      tick();
      checks++;
      if (out_locked !== 5'b0) begin
         errors++; $display("FAIL single_locked: got %b want 00000", out_locked);
      end
   endtask

   task automatic test_wormhole();
      logic [31:0] p;
      p = 32'h1234_5678;
      put(3, mk(2'b10, 4'b0000, p), 4'b0010, 4'b0001, 3'd2);
      expect_out(1, mk(2'b10, 4'b0001, {3'd2, p[28:0]}));
      tick();
      checks++;
      if (out_locked !== 5'b00010) begin
         errors++; $display("FAIL wh_lock_hdr: got %b want 00010", out_locked);
      end
      for (int b = 0; b < 3; b++) begin
         p = 32'h0BAD_0000 + 32'(b);
         // Select points elsewhere and lookahead is set: both must be ignored.
         put(3, mk(2'b00, 4'b1111, p), 4'b1000, 4'b0001, 3'd5);
         expect_out(1, mk(2'b00, 4'b0001, p));
         tick();
         checks++;
         if (out_locked !== 5'b00010) begin
            errors++; $display("FAIL wh_lock_body%0d: got %b want 00010", b, out_locked);
         end
      end
      p = 32'h0EED_0001;
      put(3, mk(2'b01, 4'b0000, p), 4'b1000, 4'b0001, 3'd5);
      expect_out(1, mk(2'b01, 4'b0001, p));
      tick();
      checks++;
      if (out_locked !== 5'b0) begin
         errors++; $display("FAIL wh_unlock: got %b want 00000", out_locked);
      end
   endtask

   task automatic test_concurrent();
      logic [3:0]  sel_t [P];
      logic [31:0] p;
      sel_t = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};  // input i -> output (i+1)%5
      for (int i = 0; i < P; i++) begin
         p = 32'hC000_0000 + 32'(i);
         put(i, mk(2'b10, 4'b0000, p), sel_t[i], 4'(1 << (i % 4)), 3'(i));
         expect_out((i + 1) % P, mk(2'b10, 4'(1 << (i % 4)), {3'(i), p[28:0]}));
      end
      tick();
      checks++;
      if (out_locked !== 5'b11111) begin
         errors++; $display("FAIL conc_locked: got %b want 11111", out_locked);
      end
      checks++;
      if (conflict_err !== 5'b0) begin
         errors++; $display("FAIL conc_err: got %b want 00000", conflict_err);
      end
      for (int i = 0; i < P; i++) begin
         p = 32'hD000_0000 + 32'(i);
         put(i, mk(2'b01, 4'b0000, p), 4'b0000, 4'(1 << ((i + 1) % 4)), 3'd0);
         expect_out((i + 1) % P, mk(2'b01, 4'(1 << ((i + 1) % 4)), p));
      end
      tick();
      checks++;
      if (out_locked !== 5'b0) begin
         errors++; $display("FAIL conc_unlock: got %b want 00000", out_locked);
      end
   endtask

   task automatic test_collision();
      logic [31:0] p1, p4;
      p1 = 32'h1111_1111;
      p4 = 32'h4444_4444;
      put(1, mk(2'b10, 4'b0000, p1), 4'b0001, 4'b0010, 3'd4);
      put(4, mk(2'b10, 4'b0000, p4), 4'b0001, 4'b1000, 3'd1);
      expect_out(0, mk(2'b10, 4'b0010, {3'd4, p1[28:0]}));
      tick();
      checks++;
      if (conflict_err !== 5'b00001) begin
         errors++; $display("FAIL coll_err: got %b want 00001", conflict_err);
      end
      checks++;
      if (out_locked !== 5'b00001) begin
         errors++; $display("FAIL coll_locked: got %b want 00001", out_locked);
      end
      // Owner is input 1: its body goes through, input 4's body is dropped.
      put(1, mk(2'b00, 4'b0000, 32'h0000_0B01), 4'b0000, 4'b0100, 3'd0);
      put(4, mk(2'b00, 4'b0000, 32'h0000_0B04), 4'b0000, 4'b0001, 3'd0);
      expect_out(0, mk(2'b00, 4'b0100, 32'h0000_0B01));
      tick();
      put(1, mk(2'b01, 4'b0000, 32'h0000_0E01), 4'b0000, 4'b0100, 3'd0);
      expect_out(0, mk(2'b01, 4'b0100, 32'h0000_0E01));
      tick();
      checks++;
      if (out_locked !== 5'b0 || conflict_err !== 5'b00001) begin
         errors++;
         $display("FAIL coll_after: got locked %b err %b want 00000 00001", out_locked,
                  conflict_err);
      end
   endtask

   task automatic test_intrusion();
      logic [31:0] p;
      p = 32'h2222_0000;
      put(0, mk(2'b10, 4'b0000, p), 4'b0010, 4'b0001, 3'd1);
      expect_out(2, mk(2'b10, 4'b0001, {3'd1, p[28:0]}));
      tick();
      put(0, mk(2'b00, 4'b0000, 32'h0000_00B1), 4'b0000, 4'b0001, 3'd0);
      put(4, mk(2'b10, 4'b0000, 32'h4000_0000), 4'b0100, 4'b0010, 3'd2);
      expect_out(2, mk(2'b00, 4'b0001, 32'h0000_00B1));
      tick();
      checks++;
      if (conflict_err !== 5'b00101) begin
         errors++; $display("FAIL intr_err: got %b want 00101", conflict_err);
      end
      checks++;
      if (out_locked !== 5'b00100) begin
         errors++; $display("FAIL intr_locked: got %b want 00100", out_locked);
      end
      put(0, mk(2'b00, 4'b0000, 32'h0000_00B2), 4'b0000, 4'b0001, 3'd0);
      expect_out(2, mk(2'b00, 4'b0001, 32'h0000_00B2));
      tick();
      put(0, mk(2'b01, 4'b0000, 32'h0000_00E1), 4'b0000, 4'b0001, 3'd0);
      expect_out(2, mk(2'b01, 4'b0001, 32'h0000_00E1));
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] p;
      p = 32'h3333_0000;
      put(1, mk(2'b10, 4'b0000, p), 4'b0100, 4'b0100, 3'd0);
      expect_out(3, mk(2'b10, 4'b0100, {3'd0, p[28:0]}));
      tick();
      put(1, mk(2'b01, 4'b0000, 32'h0000_0E11), 4'b0000, 4'b0100, 3'd0);
      put(2, mk(2'b10, 4'b0000, 32'h0000_0F22), 4'b0100, 4'b1000, 3'd3);
      expect_out(3, mk(2'b01, 4'b0100, 32'h0000_0E11));
      tick();
      checks++;
      if (conflict_err !== 5'b01101 || out_locked !== 5'b0) begin
         errors++;
         $display("FAIL b2b_state: got err %b locked %b want 01101 00000", conflict_err,
                  out_locked);
      end
      p = 32'h5555_0000;
      put(2, mk(2'b11, 4'b0000, p), 4'b0100, 4'b1000, 3'd3);
      expect_out(3, mk(2'b11, 4'b1000, {3'd3, p[28:0]}));
      tick();
   endtask

   task automatic test_reset_mid_packet();
      logic [31:0] p;
      p = 32'h6666_0000;
      put(3, mk(2'b10, 4'b0000, p), 4'b0010, 4'b0001, 3'd0);
      expect_out(1, mk(2'b10, 4'b0001, {3'd0, p[28:0]}));
      tick();
      put(3, mk(2'b00, 4'b0000, 32'h0000_0BB1), 4'b0000, 4'b0001, 3'd0);
      expect_out(1, mk(2'b00, 4'b0001, 32'h0000_0BB1));
      tick();
      #2 reset = 1'b1;
      #1;
      test_reset();
      @(negedge clk);
      reset = 1'b0;
      put(3, mk(2'b00, 4'b0000, 32'h0000_0BB2), 4'b0000, 4'b0001, 3'd0);
      tick();
      put(3, mk(2'b01, 4'b0000, 32'h0000_0EE1), 4'b0000, 4'b0001, 3'd0);
      tick();
      checks++;
      if (out_locked !== 5'b0 || flit_out_array !== '0) begin
         errors++;
         $display("FAIL rmp_orphan: got locked %b flits %h want 0 0", out_locked,
                  flit_out_array);
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_single();
      test_wormhole();
      test_concurrent();
      test_collision();
      test_intrusion();
      test_back_to_back();
      test_reset_mid_packet();
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL sb_drain: got %0d left want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vc_wormhole_cross_bar.md
# vc_wormhole_cross_bar

Parametrised, registered PORT_NUM x PORT_NUM crossbar for the VC-based mesh router with per-output wormhole connection locking. Each output tracks which input owns it, from header to tail flit. Header flits are steered by the switch-allocator port select, and body/tail flits follow the locked owner. Every flit has its output-VC field rewritten, and header flits also have their look-ahead port field rewritten. The block sits between the switch allocator/input VC buffers and the output link registers, replacing the combinational crossbar with a one-cycle registered stage.

## Interface
- PORT_NUM, 5, number of router ports (≥3)
- VC_NUM_PER_PORT, 4, VCs per port; one-hot VC id width
- PYLD_WIDTH, 32, payload bits
- FLIT_TYPE_WIDTH, 2, flit type bits (fixed at 2)
- FLIT_WIDTH, PYLD_WIDTH+FLIT_TYPE_WIDTH+VC_NUM_PER_PORT, derived
- PORT_NUM_BCD_WIDTH, log2(PORT_NUM), derived
- PORT_SEL_WIDTH, PORT_NUM-1, one-hot select width; a port never selects itself

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- flit_in_array  in  FLIT_WIDTH*PORT_NUM  input flits; slice i = input i
- flit_in_wr  in  PORT_NUM  flit valid per input
- port_sel_array  in  PORT_SEL_WIDTH*PORT_NUM  one-hot output select per input, self excluded
- look_ahead_port_sel_array  in  PORT_NUM_BCD_WIDTH*PORT_NUM  next-router port per input
- ovc_array  in  VC_NUM_PER_PORT*PORT_NUM  one-hot output VC per input
- flit_out_array  out  FLIT_WIDTH*PORT_NUM  registered output flits
- flit_out_wr  out  PORT_NUM  registered output valid
- out_locked  out  PORT_NUM  output currently owned by a packet
- conflict_err  out  PORT_NUM  sticky per-output collision flag

## Operation
- Flit layout: [FLIT_WIDTH-1 -: 2] type, next VC_NUM_PER_PORT bits ovc, low PYLD_WIDTH bits payload.
- Flit types:
  - 2'b10 header
  - 2'b00 body
  - 2'b01 tail
  - 2'b11 single (header+tail)
- Header payload [PYLD_WIDTH-1 -: PORT_NUM_BCD_WIDTH] holds the destination port field.
- Port-select index mapping: output o is selected by input i via port_sel bit o-1 if o>i, else bit o.
- Per-output FSM with states IDLE and LOCKED, and an owner register of PORT_NUM_BCD_WIDTH bits.
- IDLE:
  - A valid header/single from input i whose port_sel targets o is forwarded.
  - Header (not single): go to LOCKED, owner=i.
  - Single: stay IDLE.
  - Several inputs target o in the same cycle: lowest index wins, losers are dropped, conflict_err[o] is set.
- LOCKED:
  - A valid non-header flit from the owner is forwarded.
  - Tail: go to IDLE.
  - Body: stay LOCKED.
  - port_sel is ignored for body/tail.
  - A valid header/single from any input targeting a LOCKED output is dropped and sets conflict_err[o].
- Non-header flits from an input that owns no output are dropped silently.
- Rewrite applied to every forwarded flit:
  - ovc field ← ovc_array slice of the source input.
  - Header/single only: destination field ← source look-ahead port sel.
  - Remaining payload bits pass through unchanged.
- conflict_err bits are cleared only by reset.
- out_locked[o] = (state==LOCKED).

## Timing
- Latency: 1 cycle. A flit accepted at edge k appears on flit_out_array/flit_out_wr after edge k.
- FSM and owner update on the same edge.
- When no flit is forwarded, flit_out_wr[o]=0 and flit_out_array slice o holds its last value.
- A tail and a new header for the same output in the same cycle: the tail is forwarded, the header is dropped and sets conflict_err (state evaluated pre-edge).
- Reset (async, any time including mid-packet):
  - all FSMs → IDLE, owner=0
  - flit_out_array=0, flit_out_wr=0, out_locked=0, conflict_err=0
  - any in-flight packet is abandoned; subsequent body flits are dropped.
- No backpressure inside the block. Upstream allocation guarantees downstream credit.

## Test plan
- Single flit, PORT_NUM=5: input 0, type 2'b11, port_sel=4'b0010 (→ output 2), ovc=4'b0100, lookahead=3 → next cycle flit_out_wr=5'b00100, output 2 carries type 11, ovc 0100, dest field 3; out_locked stays 0.
- Wormhole: input 3 sends header→output 1, then 3 body, then tail → out_locked[1]=1 from the cycle after the header until the cycle after the tail; 5 consecutive flit_out_wr[1] pulses; body payloads unchanged.
- Collision: inputs 1 and 4 send headers to output 0 in the same cycle → only input 1 is forwarded; conflict_err[0]=1 and stays 1; owner=1.
- Locked intrusion: while output 2 is owned by input 0, input 4 sends a header to output 2 → dropped, conflict_err[2]=1, input 0 body flits continue unaffected.
- Concurrent paths: all 5 inputs send headers to distinct outputs (a permutation) → all 5 forwarded in one cycle, no errors, all out_locked set.
- Reset mid-packet: assert reset after a header plus 1 body → all outputs 0 immediately (async); after release, the orphan body/tail flits are dropped, flit_out_wr=0.
